// File: rtl/sysmem_ctrl.sv
// picorv32 native-bus bridge to four byte-lane BRAMs (registered output).
// Decodes one address window, sequences the BRAM access and returns a one-cycle mem_ready.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for a request that hits the window
// ST_ACCESS  | address/data on the lanes, CE high, WE = latched strobes
// ST_WAIT    | read only: CE held high while the BRAM output register fills
// ST_ACK     | mem_ready pulse, RAM idle, back to ST_IDLE
module sysmem_ctrl #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          READ_LAT  = 2
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cea,
  output logic [3:0]        ram_wea,
  output logic [31:0]       ram_dia,
  input  logic [31:0]       ram_doa
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_ACK    = 2'd3;

  logic [1:0]       state;
  logic [3:0]       wstrb_q;
  logic [CNT_W-1:0] cnt;
  logic             hit;
  logic             unused_addr_lsb;

  assign hit = (mem_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign sel = mem_valid & hit;
  assign unused_addr_lsb = ^mem_addr[1:0];

  // Gated by rsta so no lane can be written or enabled during any reset cycle
  assign ram_cea = ~rsta & ((state == ST_ACCESS) | (state == ST_WAIT));
  assign ram_wea = (~rsta && state == ST_ACCESS) ? wstrb_q : 4'b0000;

  always_ff @(posedge clka) begin
    if (rsta) begin
      state     <= ST_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      ram_addr  <= '0;
      ram_dia   <= '0;
      wstrb_q   <= '0;
      cnt       <= '0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel) begin
            ram_addr <= mem_addr[ADDR_W+1:2];
            ram_dia  <= mem_wdata;
            wstrb_q  <= mem_wstrb;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (wstrb_q != 4'b0000) begin
            // A master that has already dropped mem_valid gets no ready pulse
            mem_ready <= mem_valid;
            state     <= ST_ACK;
          end else begin
            cnt   <= CNT_LOAD;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            mem_rdata <= ram_doa;
            mem_ready <= mem_valid;
            state     <= ST_ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysmem_ctrl.sv
// Bench for sysmem_ctrl: byte-lane BRAM model, word-level reference memory and a per-cycle
// timeline compare, plus directed literal checks and randomized traffic.
module tb_sysmem_ctrl;

  localparam int RL = 2;

  logic        clka = 1'b0;
  logic        rsta = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        sel;
  logic [9:0]  ram_addr;
  logic        ram_cea;
  logic [3:0]  ram_wea;
  logic [31:0] ram_dia;
  logic [31:0] ram_doa;

  sysmem_ctrl #(.ADDR_W(10), .BASE_ADDR(32'h0000_0000), .READ_LAT(RL)) dut (
    .clka(clka), .rsta(rsta), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .sel(sel), .ram_addr(ram_addr), .ram_cea(ram_cea),
    .ram_wea(ram_wea), .ram_dia(ram_dia), .ram_doa(ram_doa)
  );

  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  // Four byte lanes, two-stage registered read path enabled by CE
  logic [31:0] bram [1024];
  logic [31:0] stage1;
  always @(posedge clka) begin
    if (ram_cea) begin
      for (int n = 0; n < 4; n++)
        if (ram_wea[n]) bram[ram_addr][8*n +: 8] <= ram_dia[8*n +: 8];
      stage1  <= bram[ram_addr];
      ram_doa <= stage1;
    end
  end

  logic [31:0] ref_mem [1024];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected timeline of the transaction in flight
  logic        act = 1'b0;
  logic        is_wr = 1'b0;
  int          t_acc = 0;
  int          abort_cyc = 1 << 30;
  logic [3:0]  exp_strb = '0;
  logic [9:0]  exp_waddr = '0;
  logic [31:0] exp_wdata = '0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] got_rdata = '0;
  logic [9:0]  acc_addr = '0;
  int          rdy_lat = -1;

  always @(negedge clka) begin
    if (cyc >= 1) begin
      int  last_cea, rdy_c;
      logic e_cea, e_rdy, e_acc;
      last_cea = is_wr ? t_acc + 1 : t_acc + 1 + RL;
      rdy_c    = is_wr ? t_acc + 2 : t_acc + 2 + RL;
      e_cea = act && cyc >= t_acc + 1 && cyc <= last_cea && cyc < abort_cyc;
      e_acc = act && cyc == t_acc + 1 && cyc < abort_cyc;
      e_rdy = act && cyc == rdy_c && cyc < abort_cyc;
      chk("sel", 32'(sel), 32'(mem_valid && mem_addr[31:12] == 20'h0));
      chk("ram_cea", 32'(ram_cea), 32'(e_cea));
      chk("ram_wea", 32'(ram_wea), 32'((e_acc && is_wr) ? exp_strb : 4'b0));
      chk("mem_ready", 32'(mem_ready), 32'(e_rdy));
      if (e_cea) begin
        chk("ram_addr", 32'(ram_addr), 32'(exp_waddr));
        if (is_wr) chk("ram_dia", ram_dia, exp_wdata);
      end
      if (e_rdy && !is_wr) chk("mem_rdata", mem_rdata, exp_rdata);
      if (act && cyc == t_acc + 1) acc_addr = ram_addr;
      if (mem_ready) begin
        rdy_lat   = cyc - t_acc;
        got_rdata = mem_rdata;
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                        input int abort_k);
    logic h;
    int   w;
    h = (a[31:12] == 20'h0);
    w = int'(a[11:2]);
    @(posedge clka); #1;
    got_rdata = '0; rdy_lat = -1; acc_addr = '0;
    abort_cyc = 1 << 30;
    t_acc = cyc; is_wr = (st != 4'b0); exp_strb = st;
    exp_waddr = a[11:2]; exp_wdata = wd; exp_rdata = ref_mem[w];
    act = h;
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = st;
    if (!h) begin
      repeat (20) @(posedge clka);
      #1 mem_valid = 1'b0;
    end else if (abort_k > 0) begin
      repeat (abort_k) @(posedge clka);
      #1;
      abort_cyc = cyc; rsta = 1'b1; mem_valid = 1'b0;
      @(posedge clka); #1 rsta = 1'b0;
      @(negedge clka);
      chk("rst_rdata", mem_rdata, 32'h0);
      chk("rst_addr", 32'(ram_addr), 32'h0);
    end else begin
      repeat ((st != 4'b0) ? 3 : 3 + RL) @(posedge clka);
      #1 mem_valid = 1'b0;
      for (int n = 0; n < 4; n++)
        if (st[n]) ref_mem[w][8*n +: 8] = wd[8*n +: 8];
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      bram[i]    = $urandom;
      ref_mem[i] = bram[i];
    end
    repeat (3) @(posedge clka);
    #1 rsta = 1'b0;
    @(negedge clka);
    chk("reset_ready", 32'(mem_ready), 32'h0);
    chk("reset_rdata", mem_rdata, 32'h0);
    chk("reset_addr", 32'(ram_addr), 32'h0);
    chk("reset_dia", ram_dia, 32'h0);

    do_req(32'h10, 32'hDEADBEEF, 4'hF, 0);
    chk("t1_addr", 32'(acc_addr), 32'h4);
    chk("t1_lat", 32'(rdy_lat), 32'd2);
    do_req(32'h10, 32'h0, 4'h0, 0);
    chk("t2_lat", 32'(rdy_lat), 32'd4);
    chk("t2_data", got_rdata, 32'hDEADBEEF);
    do_req(32'h10, 32'h0000AA00, 4'b0010, 0);
    do_req(32'h10, 32'h0, 4'h0, 0);
    chk("t3_data", got_rdata, 32'hDEADAAEF);
    do_req(32'h0000_1000, 32'h0, 4'h0, 0);
    chk("t4_lat", 32'(rdy_lat), 32'hFFFF_FFFF);
    do_req(32'h0FFC, 32'h12345678, 4'hF, 0);
    chk("t5_addr", 32'(acc_addr), 32'h3FF);
    do_req(32'h0FFC, 32'h0, 4'h0, 0);
    chk("t5_data", got_rdata, 32'h12345678);
    do_req(32'h0, 32'h0, 4'h0, 0);
    do_req(32'h10, 32'h0, 4'h0, 2);
    do_req(32'h10, 32'hFFFF_FFFF, 4'hF, 1);
    chk("t6_noready", 32'(rdy_lat), 32'hFFFF_FFFF);
    do_req(32'h10, 32'h0, 4'h0, 0);
    chk("t6_lat", 32'(rdy_lat), 32'd4);
    chk("t6_data", got_rdata, 32'hDEADAAEF);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      logic [3:0]  st;
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        if (a[31:12] == 20'h0) a[12] = 1'b1;
      end else begin
        a = '0;
        a[11:2] = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 7))
                                              : 10'($urandom_range(0, 1023));
        a[1:0] = 2'($urandom_range(0, 3));
      end
      st = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      do_req(a, $urandom, st, 0);
    end

    repeat (2) @(posedge clka);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
